// File: rtl/fix_acc_seq_if.sv
// fix_acc_seq_if: control, operand-stream and result-stream signals of the
// fixed-point accumulation sequencer.
// Optional feature macro: FIX_ACC_SAT_FLAG_EN adds the sticky sat_flag signal.
interface fix_acc_seq_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] bias;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;
`ifdef FIX_ACC_SAT_FLAG_EN
   logic         sat_flag;
`endif

   // Producer/consumer side: drives commands and operands, takes results.
   modport master (
      output start, bias, in_valid, in_data, out_ready,
`ifdef FIX_ACC_SAT_FLAG_EN
      input  sat_flag,
`endif
      input  in_ready, out_valid, out_data, busy
   );

   // Sequencer side.
   modport slave (
      input  start, bias, in_valid, in_data, out_ready,
`ifdef FIX_ACC_SAT_FLAG_EN
      output sat_flag,
`endif
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fix_acc_seq.sv
// fix_acc_seq: accumulates N signed operands onto a bias through one
// saturating adder (clamp applied at every step, symmetric range, -2^(W-1)
// never produced) and presents the result on a valid/ready output.
// Optional feature macro: FIX_ACC_SAT_FLAG_EN adds a sticky saturation flag.
module fix_acc_seq #(
   parameter int W  = 16,
   parameter int N  = 784,
   parameter int CW = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   fix_acc_seq_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic signed [W:0] MAX_C  = $signed({2'b00, {(W-1){1'b1}}});
   localparam logic signed [W:0] MIN_C  = -MAX_C;
   localparam logic [CW-1:0]     LAST_C = CW'(N - 1);

   // Exact sum of two W-bit signed values at W+1 bits (cannot overflow).
   function automatic logic signed [W:0] ext_sum(input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      return $signed({a[W-1], a}) + $signed({b[W-1], b});
   endfunction

   // Clamp an exact sum into the symmetric range [MIN, MAX].
   function automatic logic [W-1:0] sat_val(input logic signed [W:0] s);
      if (s > MAX_C) begin
         return MAX_C[W-1:0];
      end else if (s < MIN_C) begin
         return MIN_C[W-1:0];
      end else begin
         return s[W-1:0];
      end
   endfunction

   // True when the exact sum lies outside the symmetric range.
   function automatic logic sat_hit(input logic signed [W:0] s);
      return (s > MAX_C) || (s < MIN_C);
   endfunction

   state_t            state_q, state_d;
   logic [W-1:0]      acc_q,   acc_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic signed [W:0] load_sum_s;
   logic signed [W:0] step_sum_s;
`ifdef FIX_ACC_SAT_FLAG_EN
   logic              sat_q,   sat_d;
`endif

   // State, accumulator and term counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= {W{1'b0}};
         cnt_q   <= {CW{1'b0}};
`ifdef FIX_ACC_SAT_FLAG_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef FIX_ACC_SAT_FLAG_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // Next-state logic: bias load in IDLE, one saturating step per accepted operand.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
`ifdef FIX_ACC_SAT_FLAG_EN
      sat_d      = sat_q;
`endif
      load_sum_s = ext_sum(bus.bias, {W{1'b0}});
      step_sum_s = ext_sum(acc_q, bus.in_data);
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_ACC;
               acc_d   = sat_val(load_sum_s);
               cnt_d   = {CW{1'b0}};
`ifdef FIX_ACC_SAT_FLAG_EN
               sat_d   = sat_hit(load_sum_s);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (bus.in_valid) begin
               acc_d = sat_val(step_sum_s);
               cnt_d = cnt_q + CW'(1);
`ifdef FIX_ACC_SAT_FLAG_EN
               sat_d = sat_q | sat_hit(step_sum_s);
`endif
               // The handshake that brings the count to N closes the stream.
               if (cnt_q == LAST_C) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from state or driven straight from registers.
   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_data  = acc_q;
`ifdef FIX_ACC_SAT_FLAG_EN
   assign bus.sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_fix_acc_seq.sv
// tb_fix_acc_seq: directed and randomized checks of fix_acc_seq (W=8) on an
// N=4 instance and an N=1 instance against an integer reference model.
module tb_fix_acc_seq;
   localparam int W    = 8;
   localparam int MAXV = (1 <<< (W - 1)) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fix_acc_seq_if #(.W(W)) bus4();
   fix_acc_seq_if #(.W(W)) bus1();

   fix_acc_seq #(.W(W), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   fix_acc_seq #(.W(W), .N(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int x);
      if (x > MAXV) return MAXV;
      if (x < -MAXV) return -MAXV;
      return x;
   endfunction

   // Reference: chain of saturating adds starting from sat(bias).
   task automatic ref_acc(input int b, input int ops[4], output int res, output int flg);
      res = clamp(b);
      flg = (res != b) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         if (clamp(res + ops[i]) != res + ops[i]) flg = 1;
         res = clamp(res + ops[i]);
      end
   endtask

   task automatic run4(input int b, input int ops[4], input bit gaps, input int hold);
      int idx, cyc, expv, expf, tmp;
      ref_acc(b, ops, expv, expf);
      @(negedge clk);
      check("idle_busy", bus4.busy, 0);
      check("idle_in_ready", bus4.in_ready, 0);
      @(posedge clk); #1;
      bus4.start = 1'b1;
      bus4.bias  = W'(b);
      @(posedge clk); #1;
      bus4.start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 64) begin
         bus4.start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         if (gaps && $urandom_range(0, 1) == 0) begin
            bus4.in_valid = 1'b0;
            bus4.in_data  = W'($urandom);
         end else begin
            tmp = ops[idx];
            bus4.in_valid = 1'b1;
            bus4.in_data  = tmp[W-1:0];
         end
         @(negedge clk);
         check("acc_in_ready", bus4.in_ready, 1);
         check("acc_out_valid", bus4.out_valid, 0);
         @(posedge clk);
         if (bus4.in_valid) idx++;
         cyc++;
         #1;
      end
      bus4.in_valid = 1'b0;
      bus4.start    = 1'b0;
      if (!gaps) check("b2b_cycles", cyc, 4);
      bus4.out_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         check("done_out_valid", bus4.out_valid, 1);
         check("done_in_ready", bus4.in_ready, 0);
         check("done_busy", bus4.busy, 1);
         check("done_out_data", $signed(bus4.out_data), expv);
`ifdef FIX_ACC_SAT_FLAG_EN
         check("done_sat_flag", bus4.sat_flag, expf);
`endif
         // Extra stream beats and start pulses must be ignored in DONE.
         if (h == hold) begin
            bus4.out_ready = 1'b1;
         end else begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = W'($urandom);
            bus4.start    = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.start     = 1'b0;
      @(negedge clk);
      check("post_out_valid", bus4.out_valid, 0);
      check("post_busy", bus4.busy, 0);
   endtask

   initial begin
      int b, ops[4];
      bus4.start = 1'b0; bus4.bias = '0; bus4.in_valid = 1'b0;
      bus4.in_data = '0; bus4.out_ready = 1'b0;
      bus1.start = 1'b0; bus1.bias = '0; bus1.in_valid = 1'b0;
      bus1.in_data = '0; bus1.out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready", bus4.in_ready, 0);
      check("rst_out_valid", bus4.out_valid, 0);
      check("rst_out_data", $signed(bus4.out_data), 0);
      check("rst_busy", bus4.busy, 0);
      check("rst1_busy", bus1.busy, 0);
`ifdef FIX_ACC_SAT_FLAG_EN
      check("rst_sat_flag", bus4.sat_flag, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run4(0, '{10, 20, 30, 40}, 1'b0, 0);
      run4(0, '{100, 100, -50, -50}, 1'b0, 1);
      run4(-100, '{-100, -128, 0, 0}, 1'b0, 0);
      run4(-128, '{5, -128, 127, 3}, 1'b1, 3);

      // Reset in the middle of an accumulation
      @(posedge clk); #1;
      bus4.start = 1'b1; bus4.bias = W'(0);
      @(posedge clk); #1;
      bus4.start = 1'b0; bus4.in_valid = 1'b1; bus4.in_data = W'(50);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", bus4.in_ready, 0);
      check("midrst_out_valid", bus4.out_valid, 0);
      check("midrst_out_data", $signed(bus4.out_data), 0);
      check("midrst_busy", bus4.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run4(5, '{1, 1, 1, 1}, 1'b0, 0);

      // Randomized accumulations
      for (int r = 0; r < 20; r++) begin
         b = int'($urandom_range(0, 255)) - 128;
         for (int i = 0; i < 4; i++) ops[i] = int'($urandom_range(0, 255)) - 128;
         run4(b, ops, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // N=1: bias 127 plus 1 saturates, result one cycle after the operand
      @(posedge clk); #1;
      bus1.start = 1'b1; bus1.bias = W'(127);
      @(posedge clk); #1;
      bus1.start = 1'b0; bus1.in_valid = 1'b1; bus1.in_data = W'(1);
      @(negedge clk);
      check("n1_in_ready", bus1.in_ready, 1);
      check("n1_out_valid_early", bus1.out_valid, 0);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      @(negedge clk);
      check("n1_out_valid", bus1.out_valid, 1);
      check("n1_out_data", $signed(bus1.out_data), 127);
`ifdef FIX_ACC_SAT_FLAG_EN
      check("n1_sat_flag", bus1.sat_flag, 1);
`endif
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      @(negedge clk);
      check("n1_post_busy", bus1.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fix_acc_seq.md
# fix_acc_seq

Sequencer that drives a single saturating fixed-point adder to accumulate a fixed-length stream of signed operands (one neuron's weighted products) onto a bias. The result is then presented on a valid/ready output. It sits between the product stream of a neuron layer and the activation stage. Saturation is applied at every addition step, so the result matches a chain of saturating adds, not a clamp of the exact sum.

## Interface
- `W`, default 16: operand, bias and result width, signed two's complement.
- `N`, default 784: number of operands per accumulation; legal range is N ≥ 1.
- `CW`, default `$clog2(N+1)`: term counter width.

Ports:
- `clk` input, 1 bit: sole clock; everything is rising-edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low. Asserted → all state cleared immediately.
- `start` input, 1 bit: begin an accumulation. Sampled only in IDLE.
- `bias` input, W bits: initial accumulator value. Sampled on an accepted `start`.
- `in_valid` input, 1 bit: operand present.
- `in_ready` output, 1 bit: operand accepted this cycle when both `in_valid` and `in_ready` are high.
- `in_data` input, W bits: signed operand.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_data` output, W bits: accumulated result.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Symmetric saturation range: MIN = −(2^(W−1)−1), MAX = 2^(W−1)−1. The value −2^(W−1) is never produced.
- Step function `sat(x)`:
  - The sum is formed at W+1 bits, sign-extended.
  - Result is clamped to [MIN, MAX].
  - An input of −2^(W−1) is a legal operand and is used at its true value.
- States:
  - IDLE:
    - `in_ready`=0, `out_valid`=0.
    - On `start`: acc ← sat(bias), cnt ← 0, go to ACC.
  - ACC:
    - `in_ready`=1.
    - Each handshake: acc ← sat(acc + in_data), cnt ← cnt+1.
    - The handshake that brings cnt to N moves to DONE.
    - Cycles without `in_valid` hold all state.
  - DONE:
    - `in_ready`=0, `out_valid`=1, `out_data`=acc, stable until the handshake.
    - On `out_ready`: go to IDLE.
- `start` outside IDLE is ignored, with no effect on acc, cnt or state.
- `out_data` equals acc in all states. It is only meaningful while `out_valid`=1.
- No operand is ever accepted in IDLE or DONE. Extra stream beats wait for the next `start`.

## Timing
- Reset values:
  - state=IDLE, acc=0, cnt=0.
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0.
  - `sat_flag`=0 when present.
- `start` accepted at edge k:
  - ACC (and `in_ready`=1) is visible in cycle k+1.
  - The first operand can be accepted at edge k+1.
- With `in_valid` held high, the N-th operand is accepted at edge k+N. `out_valid` rises in cycle k+N+1.
- `out_ready` high while `out_valid`=1 at edge j:
  - IDLE in cycle j+1.
  - A new `start` is accepted no earlier than edge j+1.
  - Minimum start-to-start period is N+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset mid-operation discards the partial accumulation. The block restarts from IDLE after `rst_n` deasserts.

## Configuration
- `FIX_ACC_SAT_FLAG_EN` defined:
  - Adds output `sat_flag` (1 bit).
  - Cleared on an accepted `start`.
  - Set, sticky, on any step where clamping occurred, including bias load.
  - Valid alongside `out_valid`.
- `FIX_ACC_SAT_FLAG_EN` undefined: the port and its logic are absent. Datapath behaviour is identical either way.

## Test plan
- W=8, N=4, bias=0, operands 10,20,30,40 back-to-back: `out_valid` in cycle start+5, `out_data`=100, `sat_flag`=0.
- W=8, N=4, bias=0, operands 100,100,−50,−50: per-step saturation gives `out_data`=27 (127−50−50), `sat_flag`=1. The exact sum of 100 must not appear.
- W=8, N=2, bias=−100, operands −100,−128: `out_data`=−127. The value −128 is never produced.
- W=8, N=3, `in_valid` toggling 1,0,0,1,0,1 and `out_ready` low for 3 cycles: exactly 3 operands accepted. `out_data` is held stable, `in_ready`=0 in DONE. `start` pulses during ACC and DONE are ignored.
- W=8, N=4, `rst_n` pulsed low after 2 operands: all outputs return to their reset values immediately. A new start with bias=5 and operands 1,1,1,1 gives `out_data`=9.
- W=8, N=1, bias=127, operand 1: `out_data`=127, `sat_flag`=1, `out_valid` in cycle start+2.
